// File: rtl/clock_phase_pkg.sv
// Shared constants and helpers for the four-phase clock generator.
// Latency: n/a (package only).
// Backpressure: n/a; the generator is throttled only by its enable input.
package clock_phase_pkg;

    localparam int DIV_W  = 4;
    localparam int HOLD_W = 8;

    localparam logic [1:0] PH_IMEM  = 2'd0;
    localparam logic [1:0] PH_PROC0 = 2'd1;
    localparam logic [1:0] PH_DMEM  = 2'd2;
    localparam logic [1:0] PH_RF    = 2'd3;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // One bit per derived clock; packed so the decode flops load in one assignment.
    typedef struct packed {
        logic rf;
        logic dmem;
        logic proc;
        logic imem;
    } clk_vec_t;

    // Clock levels for a given phase. The processor clock spans phases 1 and 2.
    function automatic clk_vec_t decode_clocks(input logic [1:0] ph);
        clk_vec_t c;
        c.imem = (ph == PH_IMEM);
        c.proc = (ph == PH_PROC0) || (ph == PH_DMEM);
        c.dmem = (ph == PH_DMEM);
        c.rf   = (ph == PH_RF);
        return c;
    endfunction

endpackage

// File: rtl/clock_phase_gen_phase_divider.sv
// Master-clock divider and two-bit phase ring.
// Latency: phase updates on the edge after the last divide count; next_phase is combinational look-ahead.
// Backpressure: enable=0 freezes div_cnt and phase; no other stall source.
module phase_divider
    import clock_phase_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic [1:0] phase,
    output logic [1:0] next_phase,
    output logic       advance,
    output logic       wrap_pulse
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic [1:0]       phase_q;
    logic [1:0]       phase_d;

    // The phase steps when the divide count reaches its last value.
    assign advance    = enable && (div_cnt_q == DIV_LAST);
    assign wrap_pulse = advance && (phase_q == PH_RF);

    // Next divide count and phase; both hold while enable is low.
    always_comb begin
        div_cnt_d = div_cnt_q;
        phase_d   = phase_q;
        if (enable) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                phase_d   = phase_q + 2'd1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
            phase_q   <= PH_IMEM;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
        end
    end

    assign phase      = phase_q;
    assign next_phase = phase_d;

endmodule

// File: rtl/clock_phase_gen.sv
// Derives imem/processor/dmem/regfile clocks, phase strobes and a sequenced processor reset from one master clock.
// Latency: all outputs are flops updated on the same edge as phase; proc_reset_n rises on the wrap completing RST_HOLD frames.
// Backpressure: enable=0 holds counters and clock levels and zeroes the strobes on the next edge.
module clock_phase_gen
    import clock_phase_pkg::*;
#(
    parameter int DIV      = 1,
    parameter int RST_HOLD = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic       imem_clock,
    output logic       processor_clock,
    output logic       dmem_clock,
    output logic       regfile_clock,
    output logic       imem_en,
    output logic       proc_en,
    output logic       dmem_en,
    output logic       rf_en,
    output logic [1:0] phase,
    output logic       proc_reset_n,
    output logic       ready
);

    localparam logic [HOLD_W-1:0] HOLD_TGT = HOLD_W'(RST_HOLD);

    logic [1:0]        next_phase;
    logic              advance;
    logic              wrap_pulse;

    clk_vec_t          clk_q;
    clk_vec_t          clk_d;
    logic [3:0]        stb_q;
    logic [3:0]        stb_d;
    state_e            state_q;
    state_e            state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              prn_q;
    logic              prn_d;

    phase_divider #(
        .DIV (DIV)
    ) u_div (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .phase      (phase),
        .next_phase (next_phase),
        .advance    (advance),
        .wrap_pulse (wrap_pulse)
    );

    // Clock levels reload only when the phase actually changes. This keeps every
    // clock low during the initial phase 0 after reset, so the first imem pulse
    // follows the first 3->0 wrap, and holds the levels while enable is low.
    always_comb begin
        clk_d = clk_q;
        if (advance) begin
            clk_d = decode_clocks(next_phase);
        end
    end

    // One-cycle strobe for the phase being entered on this edge.
    always_comb begin
        stb_d = '0;
        if (advance) begin
            stb_d[next_phase] = 1'b1;
        end
    end

    // Reset sequencer: count completed frames, release the processor on the
    // wrap that reaches RST_HOLD. hold_cnt never exceeds RST_HOLD.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        prn_d      = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (RST_HOLD == 0) begin
                    state_d = ST_RUN;
                    prn_d   = 1'b1;
                end else if (wrap_pulse) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    if (hold_cnt_d == HOLD_TGT) begin
                        state_d = ST_RUN;
                        prn_d   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                prn_d = 1'b1;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // Output decode, strobe and sequencer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_q      <= '0;
            stb_q      <= '0;
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            prn_q      <= 1'b0;
        end else begin
            clk_q      <= clk_d;
            stb_q      <= stb_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            prn_q      <= prn_d;
        end
    end

    assign imem_clock      = clk_q.imem;
    assign processor_clock = clk_q.proc;
    assign dmem_clock      = clk_q.dmem;
    assign regfile_clock   = clk_q.rf;

    assign imem_en = stb_q[PH_IMEM];
    assign proc_en = stb_q[PH_PROC0];
    assign dmem_en = stb_q[PH_DMEM];
    assign rf_en   = stb_q[PH_RF];

    assign proc_reset_n = prn_q;
    assign ready        = prn_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Bench for clock_phase_gen: four instances with different DIV/RST_HOLD share clock, reset and enable.
// Expected outputs come from an arithmetic model (enabled edge count -> phase, frames, strobes).
// A monitor pops the expected vector once per edge and compares every instance.
module tb_clock_phase_gen;

    localparam int NI = 4;

    function automatic int div_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            default: return 16;
        endcase
    endfunction

    function automatic int hold_of(input int i);
        case (i)
            0:       return 0;
            1:       return 2;
            2:       return 1;
            default: return 255;
        endcase
    endfunction

    typedef struct packed {
        logic [1:0] phase;
        logic [3:0] clks;   // {rf, dmem, proc, imem}
        logic [3:0] strb;   // {rf_en, dmem_en, proc_en, imem_en}
        logic       prn;
        logic       rdy;
    } obs_t;

    typedef obs_t [NI-1:0] obs_vec_t;

    logic clock;
    logic reset;
    logic enable;

    obs_t act [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic       im_c, pc_c, dm_c, rf_c;
        logic       im_e, pc_e, dm_e, rf_e;
        logic [1:0] ph_w;
        logic       prn_w, rdy_w;

        clock_phase_gen #(
            .DIV      (div_of(g)),
            .RST_HOLD (hold_of(g))
        ) u_dut (
            .clock           (clock),
            .reset           (reset),
            .enable          (enable),
            .imem_clock      (im_c),
            .processor_clock (pc_c),
            .dmem_clock      (dm_c),
            .regfile_clock   (rf_c),
            .imem_en         (im_e),
            .proc_en         (pc_e),
            .dmem_en         (dm_e),
            .rf_en           (rf_e),
            .phase           (ph_w),
            .proc_reset_n    (prn_w),
            .ready           (rdy_w)
        );

        assign act[g] = {ph_w, rf_c, dm_c, pc_c, im_c, rf_e, dm_e, pc_e, im_e, prn_w, rdy_w};
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: enabled edges since reset, and whether any phase change has happened.
    int       n_m       [NI];
    bit       started_m [NI];
    obs_vec_t exp_q [$];

    function automatic logic [3:0] clk_pattern(input int ph);
        case (ph)
            0:       return 4'b0001;
            1:       return 4'b0010;
            2:       return 4'b0110;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic bit model_released(input int i);
        if (hold_of(i) == 0) return 1'b1;
        return (n_m[i] / (4 * div_of(i))) >= hold_of(i);
    endfunction

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model: compute every instance's expected outputs after this edge and queue them.
    always @(posedge clock) begin
        obs_vec_t e;
        int       d;
        int       ph;
        bit       chg;
        bit       rel;
        for (int i = 0; i < NI; i++) begin
            d = div_of(i);
            if (!reset) begin
                n_m[i]       = 0;
                started_m[i] = 1'b0;
                e[i]         = '0;
            end else begin
                chg = 1'b0;
                if (enable) begin
                    n_m[i] = n_m[i] + 1;
                    chg    = (n_m[i] % d) == 0;
                end
                if (chg) started_m[i] = 1'b1;
                ph         = (n_m[i] / d) % 4;
                rel        = model_released(i);
                e[i].phase = 2'(ph);
                e[i].clks  = started_m[i] ? clk_pattern(ph) : 4'b0000;
                e[i].strb  = chg ? 4'(1 << ph) : 4'b0000;
                e[i].prn   = rel;
                e[i].rdy   = rel;
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: pop the expected vector and compare each instance away from the edge.
    always @(posedge clock) begin
        obs_vec_t e;
        #1;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty at %0t: no expected entry, required one", $time);
        end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < NI; i++) begin
                n_chk++;
                if (act[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL outputs inst%0d(DIV=%0d,HOLD=%0d) at %0t: got ph=%0d clk=%b stb=%b prn=%b rdy=%b, required ph=%0d clk=%b stb=%b prn=%b rdy=%b",
                             i, div_of(i), hold_of(i), $time,
                             act[i].phase, act[i].clks, act[i].strb, act[i].prn, act[i].rdy,
                             e[i].phase, e[i].clks, e[i].strb, e[i].prn, e[i].rdy);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        bit found;
        reset  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clock);
        reset  = 1'b1;
        enable = 1'b1;
        repeat (60) @(negedge clock);

        // Five-cycle freeze, then resume.
        enable = 1'b0;
        repeat (5) @(negedge clock);
        enable = 1'b1;
        repeat (40) @(negedge clock);

        // Random enable pattern.
        for (int k = 0; k < 600; k++) begin
            @(negedge clock);
            enable = ($urandom_range(0, 9) != 0);
        end
        @(negedge clock);
        enable = 1'b1;

        // Asynchronous reset between edges while the DIV=1 instance is in phase 1.
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(posedge clock);
            #3;
            if ((n_m[0] % 4) == 1) found = 1'b1;
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL phase1_search: phase 1 not reached within 8 edges, required within 8");
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            n_chk++;
            if (act[i] !== '0) begin
                n_fail++;
                $display("FAIL async_reset inst%0d: got %b between edges, required all zero", i, act[i]);
            end
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Long run until the DIV=16/RST_HOLD=255 instance releases, with sparse freezes.
        found = 1'b0;
        for (int k = 0; k < 30000 && !found; k++) begin
            @(negedge clock);
            enable = ($urandom_range(0, 63) != 0);
            if (model_released(3)) found = 1'b1;
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL long_hold_bound: DIV=16 instance not released within 30000 cycles, required release");
        end
        enable = 1'b1;
        repeat (20) @(negedge clock);
        @(posedge clock);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
